// File: rtl/clk_freq_meter.sv
// Counts rising edges of one selected asynchronous clock over a programmable
// window of clk_i cycles, then reports the count, saturation and range check.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; ready_o high
// SYNC  | 2 cycles letting the synchronizer settle; edges are discarded
// MEAS  | W cycles counting detected edges on the latched channel
// DONE  | result held on count_o/ovf_o/in_range_o; valid_o high
module clk_freq_meter #(
   parameter int NumClks  = 3,
   parameter int WinWidth = 16,
   parameter int CntWidth = 16,
   localparam int SelWidth = (NumClks > 1) ? $clog2(NumClks) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [NumClks-1:0]  meas_clk_i,
   input  logic [SelWidth-1:0] sel_i,
   input  logic [WinWidth-1:0] win_cycles_i,
   input  logic [CntWidth-1:0] lo_thr_i,
   input  logic [CntWidth-1:0] hi_thr_i,
   input  logic                req_i,
   output logic                ready_o,
   output logic                valid_o,
   input  logic                ready_i,
   output logic [CntWidth-1:0] count_o,
   output logic                ovf_o,
   output logic                in_range_o
);

   localparam int PadWidth = 1 << SelWidth;
   localparam logic [WinWidth-1:0] TmrOne = WinWidth'(1);
   localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_MEAS,
      ST_DONE
   } state_t;

   state_t state_q, state_d;

   logic [NumClks-1:0]  sync1_q, sync2_q, hist_q;
   logic [PadWidth-1:0] sync_pad, hist_pad;
   logic                edge_det;

   logic [SelWidth-1:0] sel_q;
   logic [WinWidth-1:0] win_q;
   logic [CntWidth-1:0] lo_q, hi_q;
   logic                latch_en;

   logic [WinWidth-1:0] tmr_q, tmr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
   logic                ovf_q, ovf_d;
   logic                in_range_q, in_range_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         hist_q  <= '0;
      end else begin
         sync1_q <= meas_clk_i;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   // Unused select codes map onto constant-zero channels, so they count nothing.
   always_comb begin
      sync_pad = '0;
      hist_pad = '0;
      sync_pad[NumClks-1:0] = sync2_q;
      hist_pad[NumClks-1:0] = hist_q;
   end

   assign edge_det = sync_pad[sel_q] & ~hist_pad[sel_q];
   assign cnt_inc  = cnt_q + CntOne;

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      in_range_d = in_range_q;
      latch_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               state_d    = ST_SYNC;
               tmr_d      = TmrOne;
               cnt_d      = '0;
               ovf_d      = 1'b0;
               in_range_d = 1'b0;
               latch_en   = 1'b1;
            end
         end
         ST_SYNC: begin
            if (tmr_q == '0) begin
               state_d = ST_MEAS;
               tmr_d   = (win_q == '0) ? '0 : win_q - TmrOne;
            end else begin
               tmr_d = tmr_q - TmrOne;
            end
         end
         ST_MEAS: begin
            if (edge_det && !ovf_q) begin
               cnt_d = cnt_inc;
               ovf_d = &cnt_inc;
            end
            // The range flag is taken from the final count so it lands with valid_o.
            if (tmr_q == '0) begin
               state_d    = ST_DONE;
               in_range_d = !ovf_d && (cnt_d >= lo_q) && (cnt_d <= hi_q);
            end else begin
               tmr_d = tmr_q - TmrOne;
            end
         end
         ST_DONE: begin
            if (ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         in_range_q <= in_range_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sel_q <= '0;
         win_q <= '0;
         lo_q  <= '0;
         hi_q  <= '0;
      end else if (latch_en) begin
         sel_q <= sel_i;
         win_q <= win_cycles_i;
         lo_q  <= lo_thr_i;
         hi_q  <= hi_thr_i;
      end
   end

   assign ready_o    = (state_q == ST_IDLE);
   assign valid_o    = (state_q == ST_DONE);
   assign count_o    = cnt_q;
   assign ovf_o      = ovf_q;
   assign in_range_o = in_range_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: a default instance (3 channels, 16-bit
// count) and an 8-bit-count instance for saturation.
`timescale 1ns/100ps
module tb_clk_freq_meter;

   localparam int Lim = 5000;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   logic [2:0]  meas_raw;
   logic        meas_run;
   logic [2:0]  a_meas;
   logic [1:0]  a_sel;
   logic [15:0] a_win, a_lo, a_hi;
   logic        a_req, a_ready, a_valid, a_ready_i, a_ovf, a_inr;
   logic [15:0] a_count;

   logic        b_meas;
   logic [0:0]  b_sel;
   logic [15:0] b_win;
   logic [7:0]  b_lo, b_hi, b_count;
   logic        b_req, b_ready, b_valid, b_ready_i, b_ovf, b_inr;

   assign a_meas = meas_raw & {3{meas_run}};

   clk_freq_meter u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(a_meas), .sel_i(a_sel),
      .win_cycles_i(a_win), .lo_thr_i(a_lo), .hi_thr_i(a_hi),
      .req_i(a_req), .ready_o(a_ready), .valid_o(a_valid), .ready_i(a_ready_i),
      .count_o(a_count), .ovf_o(a_ovf), .in_range_o(a_inr)
   );

   clk_freq_meter #(.NumClks(1), .WinWidth(16), .CntWidth(8)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(b_meas), .sel_i(b_sel),
      .win_cycles_i(b_win), .lo_thr_i(b_lo), .hi_thr_i(b_hi),
      .req_i(b_req), .ready_o(b_ready), .valid_o(b_valid), .ready_i(b_ready_i),
      .count_o(b_count), .ovf_o(b_ovf), .in_range_o(b_inr)
   );

   initial begin
      clk = 1'b0;
      forever #1 clk = ~clk;
   end

   // Measured clocks are offset so their edges never coincide with clk edges.
   initial begin
      meas_raw = '0;
      b_meas   = 1'b0;
      #0.3;
      fork
         forever #5 meas_raw[0] = ~meas_raw[0];
         forever #3 meas_raw[1] = ~meas_raw[1];
         forever #7 meas_raw[2] = ~meas_raw[2];
         forever #4 b_meas = ~b_meas;
      join
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start_a(input logic [1:0] sel, input logic [15:0] win,
                          input logic [15:0] lo, input logic [15:0] hi, input string tag);
      chk({tag, " ready before req"}, 32'(a_ready), 32'd1);
      a_sel = sel; a_win = win; a_lo = lo; a_hi = hi; a_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_req = 1'b0;
      a_sel = 2'd3; a_win = 16'd7; a_lo = 16'hffff; a_hi = 16'd0;
      chk({tag, " accepted"}, 32'(a_ready), 32'd0);
   endtask

   task automatic wait_a(input int exp_lat, input string tag);
      int n = 0;
      while (a_valid !== 1'b1 && n < Lim) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
   endtask

   task automatic after_hs_a(input string tag);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " valid drop"}, 32'(a_valid), 32'd0);
      chk({tag, " ready back"}, 32'(a_ready), 32'd1);
   endtask

   initial begin
      logic [15:0] c_hold;
      logic        o_hold, i_hold, stable, rdy_seen, val_lost, val_seen;
      int          n;

      rst_n = 1'b0; meas_run = 1'b0;
      a_sel = '0; a_win = '0; a_lo = '0; a_hi = '0; a_req = 1'b0; a_ready_i = 1'b1;
      b_sel = '0; b_win = '0; b_lo = '0; b_hi = '0; b_req = 1'b0; b_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst ready", 32'(a_ready), 32'd1);
      chk("rst valid", 32'(a_valid), 32'd0);
      chk("rst outs", 32'({a_count, a_ovf, a_inr}), 32'd0);

      // win=0 on a silent channel, requested on the first edge after release
      a_sel = 2'd0; a_win = 16'd0; a_lo = 16'd0; a_hi = 16'd0; a_req = 1'b1;
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_req = 1'b0;
      chk("first accept", 32'(a_ready), 32'd0);
      wait_a(3, "win0");
      chk("win0 count", 32'(a_count), 32'd0);
      chk("win0 in_range", 32'(a_inr), 32'd1);
      chk("win0 ovf", 32'(a_ovf), 32'd0);
      after_hs_a("win0");

      // 10ns clock over 1000 x 2ns window; inputs are scrambled after accept
      meas_run = 1'b1;
      repeat (10) @(negedge clk);
      start_a(2'd0, 16'd1000, 16'd199, 16'd201, "w1000");
      wait_a(1002, "w1000");
      chk("w1000 count", 32'(a_count >= 16'd199 && a_count <= 16'd201), 32'd1);
      chk("w1000 in_range", 32'(a_inr), 32'd1);
      chk("w1000 ovf", 32'(a_ovf), 32'd0);
      after_hs_a("w1000");

      start_a(2'd3, 16'd200, 16'd0, 16'hffff, "sel3");
      wait_a(202, "sel3");
      chk("sel3 count", 32'(a_count), 32'd0);
      chk("sel3 in_range", 32'(a_inr), 32'd1);
      after_hs_a("sel3");

      start_a(2'd0, 16'd200, 16'd5, 16'd2, "thr_swap");
      wait_a(202, "thr_swap");
      chk("thr_swap count", 32'(a_count >= 16'd39 && a_count <= 16'd41), 32'd1);
      chk("thr_swap in_range", 32'(a_inr), 32'd0);
      after_hs_a("thr_swap");

      // Result held for 50 cycles under back-pressure with busy inputs
      a_ready_i = 1'b0;
      start_a(2'd1, 16'd100, 16'd30, 16'd40, "hold");
      wait_a(102, "hold");
      c_hold = a_count; o_hold = a_ovf; i_hold = a_inr;
      stable = 1'b1; rdy_seen = 1'b0; val_lost = 1'b0;
      a_req = 1'b1;
      for (int i = 0; i < 50; i++) begin
         a_sel = 2'($urandom); a_win = 16'($urandom);
         a_lo  = 16'($urandom); a_hi = 16'($urandom);
         @(posedge clk);
         @(negedge clk);
         if (a_count !== c_hold || a_ovf !== o_hold || a_inr !== i_hold) stable = 1'b0;
         if (a_ready !== 1'b0) rdy_seen = 1'b1;
         if (a_valid !== 1'b1) val_lost = 1'b0 | 1'b1;
      end
      chk("hold stable", 32'(stable), 32'd1);
      chk("hold ready seen", 32'(rdy_seen), 32'd0);
      chk("hold valid lost", 32'(val_lost), 32'd0);
      chk("hold count", 32'(c_hold >= 16'd33 && c_hold <= 16'd34), 32'd1);
      chk("hold in_range", 32'(i_hold), 32'd1);
      a_req = 1'b0;
      a_ready_i = 1'b1;
      after_hs_a("hold");

      // Reset pulse mid-measurement
      start_a(2'd0, 16'd1000, 16'd0, 16'hffff, "abort");
      repeat (100) @(negedge clk);
      #0.5 rst_n = 1'b0;
      #0.1;
      chk("abort count", 32'(a_count), 32'd0);
      chk("abort ready", 32'(a_ready), 32'd1);
      chk("abort valid", 32'(a_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      val_seen = 1'b0;
      repeat (1100) begin
         @(negedge clk);
         if (a_valid !== 1'b0) val_seen = 1'b1;
      end
      chk("abort no valid", 32'(val_seen), 32'd0);
      start_a(2'd0, 16'd100, 16'd19, 16'd21, "post_rst");
      wait_a(102, "post_rst");
      chk("post_rst count", 32'(a_count >= 16'd19 && a_count <= 16'd21), 32'd1);
      chk("post_rst in_range", 32'(a_inr), 32'd1);
      after_hs_a("post_rst");

      // 8-bit instance: 500 edges in the window saturates at 255
      b_sel = 1'b0; b_win = 16'd2000; b_lo = 8'd0; b_hi = 8'd255; b_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_req = 1'b0;
      chk("sat accepted", 32'(b_ready), 32'd0);
      n = 0;
      while (b_valid !== 1'b1 && n < Lim) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk("sat latency", 32'(n), 32'd2002);
      chk("sat count", 32'(b_count), 32'd255);
      chk("sat ovf", 32'(b_ovf), 32'd1);
      chk("sat in_range", 32'(b_inr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
